// File: rtl/pfet_seq_pkg.sv
// pfet_seq_pkg: shared state encoding and default sizes for the segmented PFET sequencer
package pfet_seq_pkg;
   localparam int NSEG_DEF = 4;
   localparam int DTW_DEF  = 6;
   localparam int STW_DEF  = 4;
   typedef enum logic [2:0] {S_OFF, S_DEAD, S_RAMPON, S_ON, S_RAMPOFF, S_FAULT} state_t;
endpackage

// File: rtl/pfet_seg_select.sv
// pfet_seg_select: picks the next segment to enable (lowest pending) and to disable (highest on)
module pfet_seg_select #(
   parameter int NSEG = 4
) (
   input  logic [NSEG-1:0] mask_q,
   input  logic [NSEG-1:0] seg_on,
   output logic [NSEG-1:0] nxt_on,
   output logic [NSEG-1:0] nxt_off,
   output logic            all_on
);
   logic [NSEG-1:0] pend;
   // one-hot priority picks; all_on means enabling nxt_on completes the mask
   always_comb begin
      pend    = mask_q & ~seg_on;
      nxt_on  = '0;
      nxt_off = '0;
      for (int i = NSEG - 1; i >= 0; i--)
         if (pend[i]) begin
            nxt_on    = '0;
            nxt_on[i] = 1'b1;
         end
      for (int i = 0; i < NSEG; i++)
         if (seg_on[i]) begin
            nxt_off    = '0;
            nxt_off[i] = 1'b1;
         end
      all_on = (pend & ~nxt_on) == '0;
   end
endmodule

// File: rtl/pfet_seg_sequencer.sv
// pfet_seg_sequencer: dead-time guarded, one-segment-at-a-time ramp of a segmented power PMOS
module pfet_seg_sequencer
   import pfet_seq_pkg::*;
#(
   parameter int NSEG = NSEG_DEF,
   parameter int DTW  = DTW_DEF,
   parameter int STW  = STW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_req,
   input  logic            other_off,
   input  logic            fault,
   input  logic [DTW-1:0]  deadtime,
   input  logic [STW-1:0]  step,
   input  logic [NSEG-1:0] seg_mask,
   output logic [NSEG-1:0] seg_on,
   output logic            sw_off,
   output logic            busy,
   output logic            fault_latch,
   output logic            err_nomask
);
   state_t          state;
   logic [NSEG-1:0] mask_q, nxt_on, nxt_off, rem;
   logic [DTW-1:0]  dcnt;
   logic [STW-1:0]  scnt;
   logic            all_on, conducting;

   pfet_seg_select #(.NSEG(NSEG)) u_sel (
      .mask_q (mask_q),
      .seg_on (seg_on),
      .nxt_on (nxt_on),
      .nxt_off(nxt_off),
      .all_on (all_on)
   );

   assign rem        = seg_on & ~nxt_off;
   assign conducting = state == S_RAMPON || state == S_ON || state == S_RAMPOFF;

   // sequencing FSM with dead/step counters; every output is registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_OFF;
         mask_q      <= '0;
         dcnt        <= '0;
         scnt        <= '0;
         seg_on      <= '0;
         sw_off      <= 1'b1;
         busy        <= 1'b0;
         fault_latch <= 1'b0;
         err_nomask  <= 1'b0;
      end else if (fault || (!other_off && conducting)) begin
         state       <= S_FAULT;
         seg_on      <= '0;
         sw_off      <= 1'b1;
         busy        <= 1'b0;
         fault_latch <= 1'b1;
         err_nomask  <= 1'b0;
      end else begin
         err_nomask <= 1'b0;
         case (state)
            S_OFF: begin
               err_nomask <= en_req && seg_mask == '0;
               if (en_req && other_off && |seg_mask) begin
                  state  <= S_DEAD;
                  mask_q <= seg_mask;
                  dcnt   <= deadtime;
                  busy   <= 1'b1;
               end
            end
            S_DEAD:
               if (!en_req || !other_off) begin
                  state <= S_OFF;
                  busy  <= 1'b0;
               end else if (dcnt == '0) begin
                  seg_on <= nxt_on;
                  sw_off <= 1'b0;
                  scnt   <= step;
                  state  <= all_on ? S_ON : S_RAMPON;
                  busy   <= !all_on;
               end else
                  dcnt <= dcnt - DTW'(1);
            S_RAMPON, S_ON, S_RAMPOFF:
               if (state != S_RAMPOFF && en_req) begin
                  if (state == S_RAMPON) begin
                     if (scnt == '0) begin
                        seg_on <= seg_on | nxt_on;
                        scnt   <= step;
                        if (all_on) begin
                           state <= S_ON;
                           busy  <= 1'b0;
                        end
                     end else
                        scnt <= scnt - STW'(1);
                  end
               end else if (state != S_RAMPOFF || scnt == '0) begin
                  seg_on <= rem;
                  scnt   <= step;
                  state  <= rem == '0 ? S_OFF : S_RAMPOFF;
                  sw_off <= rem == '0;
                  busy   <= rem != '0;
               end else
                  scnt <= scnt - STW'(1);
            S_FAULT:
               if (!en_req && other_off) begin
                  state       <= S_OFF;
                  fault_latch <= 1'b0;
               end
            default: state <= S_OFF;
         endcase
      end
   end
endmodule

// File: tb/tb_pfet_seg_sequencer.sv
// tb_pfet_seg_sequencer: directed timeline plus random stimulus against a timing-formula reference model
module tb_pfet_seg_sequencer;
   localparam int P_OFF = 0, P_DEAD = 1, P_UP = 2, P_ON = 3, P_DOWN = 4, P_FLT = 5;

   logic       clk = 1'b0, rst_n = 1'b1, en_req = 1'b0, other_off = 1'b1, fault = 1'b0;
   logic [5:0] deadtime = 6'd3;
   logic [3:0] step = 4'd2, seg_mask = 4'hf;
   logic [3:0] seg_on;
   logic       sw_off, busy, fault_latch, err_nomask;

   int pass_cnt = 0, total = 0, cyc = 0;
   int ph = P_OFF, cnt = 0, te = 0, tf = 0, k0 = 0, md = 0, ms = 0;
   logic [3:0] mm = '0;
   logic       merr = 1'b0;

   pfet_seg_sequencer #(.NSEG(4), .DTW(6), .STW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_req     (en_req),
      .other_off  (other_off),
      .fault      (fault),
      .deadtime   (deadtime),
      .step       (step),
      .seg_mask   (seg_mask),
      .seg_on     (seg_on),
      .sw_off     (sw_off),
      .busy       (busy),
      .fault_latch(fault_latch),
      .err_nomask (err_nomask)
   );

   // free-running clock
   always #5 clk = ~clk;

   function automatic logic [3:0] first_k(logic [3:0] m, int k);
      logic [3:0] r;
      int n;
      r = '0;
      n = 0;
      for (int i = 0; i < 4; i++)
         if (m[i] && n < k) begin
            r[i] = 1'b1;
            n++;
         end
      return r;
   endfunction

   function automatic logic [7:0] outs();
      return {seg_on, sw_off, busy, fault_latch, err_nomask};
   endfunction

   function automatic logic [7:0] model_outs();
      return {first_k(mm, cnt), cnt == 0, ph == P_DEAD || ph == P_UP || ph == P_DOWN, ph == P_FLT, merr};
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at edge %0d: got seg/sw/busy/flt/err=%b expected %b", name, cyc, act, exp);
   endtask

   task automatic begin_down();
      k0  = cnt;
      tf  = cyc;
      cnt = k0 - 1;
      ph  = cnt == 0 ? P_OFF : P_DOWN;
   endtask

   task automatic drive(int n);
      while (cyc < n - 1) @(negedge clk);
   endtask

   task automatic exp_at(int n, string name, logic [7:0] v);
      while (cyc < n) @(negedge clk);
      chk(name, outs(), v);
   endtask

   // reset clears the model immediately, like the DUT
   always @(negedge rst_n) begin
      ph   = P_OFF;
      cnt  = 0;
      merr = 1'b0;
   end

   // reference model: segment count derived from elapsed cycles since request / release
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         ph   = P_OFF;
         cnt  = 0;
         merr = 1'b0;
      end else begin
         merr = 1'b0;
         if (fault || (!other_off && (ph == P_UP || ph == P_ON || ph == P_DOWN))) begin
            ph  = P_FLT;
            cnt = 0;
         end else
            case (ph)
               P_OFF: begin
                  merr = en_req && seg_mask == 4'b0;
                  if (en_req && other_off && seg_mask != 4'b0) begin
                     ph = P_DEAD;
                     te = cyc;
                     md = int'(deadtime);
                     ms = int'(step);
                     mm = seg_mask;
                  end
               end
               P_DEAD:
                  if (!en_req || !other_off) ph = P_OFF;
                  else if (cyc == te + md + 1) begin
                     cnt = 1;
                     ph  = $countones(mm) == 1 ? P_ON : P_UP;
                  end
               P_UP:
                  if (!en_req) begin_down();
                  else begin
                     cnt = 1 + (cyc - te - md - 1) / (ms + 1);
                     if (cnt >= $countones(mm)) ph = P_ON;
                  end
               P_ON: if (!en_req) begin_down();
               P_DOWN: begin
                  cnt = k0 - 1 - (cyc - tf) / (ms + 1);
                  if (cnt <= 0) begin
                     cnt = 0;
                     ph  = P_OFF;
                  end
               end
               P_FLT: if (!en_req && other_off) ph = P_OFF;
               default: ph = P_OFF;
            endcase
      end
      #2 chk("model", outs(), model_outs());
   end

   // time limit
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // directed timeline then random traffic
   initial begin
      #1 rst_n = 1'b0;
      #2 chk("reset", outs(), 8'b0000_1000);
      #9 rst_n = 1'b1;
      drive(10);  en_req = 1'b1;
      exp_at(13, "dead", 8'b0000_1100);
      exp_at(14, "on1", 8'b0001_0100);
      exp_at(16, "hold1", 8'b0001_0100);
      exp_at(17, "on2", 8'b0011_0100);
      exp_at(20, "on3", 8'b0111_0100);
      exp_at(23, "on4", 8'b1111_0000);
      drive(40);  en_req = 1'b0;
      exp_at(40, "off1", 8'b0111_0100);
      exp_at(43, "off2", 8'b0011_0100);
      exp_at(46, "off3", 8'b0001_0100);
      exp_at(49, "alloff", 8'b0000_1000);
      drive(60);  seg_mask = 4'b0101; en_req = 1'b1;
      exp_at(64, "m0101_a", 8'b0001_0100);
      drive(65);  seg_mask = 4'b1111;
      exp_at(67, "m0101_b", 8'b0101_0000);
      exp_at(75, "m0101_on", 8'b0101_0000);
      drive(80);  en_req = 1'b0;
      exp_at(80, "m0101_off1", 8'b0001_0100);
      exp_at(83, "m0101_off2", 8'b0000_1000);
      drive(90);  en_req = 1'b1;
      exp_at(91, "dead_busy", 8'b0000_1100);
      drive(92);  other_off = 1'b0;
      exp_at(92, "dead_abort", 8'b0000_1000);
      drive(93);  en_req = 1'b0;
      drive(94);  other_off = 1'b1;
      drive(100); en_req = 1'b1;
      exp_at(104, "r2_on1", 8'b0001_0100);
      exp_at(113, "r2_on4", 8'b1111_0000);
      drive(120); other_off = 1'b0;
      exp_at(120, "shoot_through", 8'b0000_1010);
      drive(122); other_off = 1'b1;
      exp_at(123, "fault_hold", 8'b0000_1010);
      drive(125); en_req = 1'b0;
      exp_at(125, "fault_exit", 8'b0000_1000);
      drive(130); en_req = 1'b1;
      exp_at(137, "r3_on2", 8'b0011_0100);
      drive(138); fault = 1'b1;
      exp_at(138, "ext_fault", 8'b0000_1010);
      drive(140); fault = 1'b0;
      exp_at(141, "fault_en_hold", 8'b0000_1010);
      drive(143); en_req = 1'b0;
      exp_at(143, "fault_exit2", 8'b0000_1000);
      drive(150); seg_mask = 4'b0000; en_req = 1'b1;
      exp_at(150, "nomask", 8'b0000_1001);
      exp_at(151, "nomask_hold", 8'b0000_1001);
      drive(152); en_req = 1'b0;
      exp_at(152, "nomask_clr", 8'b0000_1000);
      drive(153); seg_mask = 4'b1111;
      drive(160); en_req = 1'b1;
      exp_at(170, "r4_on3", 8'b0111_0100);
      exp_at(171, "r4_hold", 8'b0111_0100);
      #1 rst_n = 1'b0;
      #1 chk("async_reset", outs(), 8'b0000_1000);
      en_req = 1'b0;
      #1 rst_n = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) en_req = ~en_req;
         other_off = $urandom_range(0, 39) != 0;
         fault     = $urandom_range(0, 99) == 0;
         if ($urandom_range(0, 7) == 0) seg_mask = 4'($urandom);
         if (ph == P_OFF && !en_req) begin
            deadtime = 6'($urandom_range(0, 5));
            step     = 4'($urandom_range(0, 3));
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/pfet_seg_sequencer.md
# pfet_seg_sequencer

Parametrised sequencer for a segmented power PMOS in the step-down driver path. It is the successor to the single-segment bottom-switch PFET and drives `NSEG` gate segments. Segments are enabled one at a time on turn-on and disabled in reverse order on turn-off. The block enforces dead time against the complementary switch and latches faults. It sits between the loop controller's switch request and the per-segment gate drivers.

## Interface
- `NSEG`, 4: number of PMOS gate segments (1–16).
- `DTW`, 6: dead-time counter width.
- `STW`, 4: inter-segment step counter width.
- `CLK` input 1: single block clock.
- `RSTN` input 1: asynchronous, active-low reset.
- `EN_REQ` input 1: switch-on request from the loop controller. Level-sensitive and already synchronous to `CLK`.
- `OTHER_OFF` input 1: complementary switch confirmed fully off. Already synchronous.
- `FAULT` input 1: external fault, forces all segments off.
- `DEADTIME` input DTW: dead-time length in cycles.
- `STEP` input STW: segment spacing. The spacing is `STEP+1` cycles.
- `SEG_MASK` input NSEG: segments participating in this switching event. Sets the effective Ron.
- `SEG_ON` output NSEG: per-segment gate command. 1 = segment conducting (gate driven low downstream).
- `SW_OFF` output 1: all segments off. Feeds the complementary driver's `OTHER_OFF`.
- `BUSY` output 1: high in DEAD, RAMPON, RAMPOFF.
- `FAULT_LATCH` output 1: high while in the FAULT state.
- `ERR_NOMASK` output 1: high while `EN_REQ`=1, the state is OFF and `SEG_MASK`=0.

## Operation
- States: OFF, DEAD, RAMPON, ON, RAMPOFF, FAULT.
- Reset values: state OFF, `SEG_ON`=0, `SW_OFF`=1, `BUSY`=0, `FAULT_LATCH`=0, `ERR_NOMASK`=0. All counters are 0.
- OFF → DEAD: requires `EN_REQ`=1, `OTHER_OFF`=1, `SEG_MASK`≠0 and `FAULT`=0. On this transition the mask is latched into `mask_q` and the dead counter is loaded with `DEADTIME`.
- `SEG_MASK` changes outside OFF are ignored.
- DEAD:
  - The dead counter decrements each cycle.
  - When it reaches 0: go to RAMPON, turn on the lowest-index set bit of `mask_q`, and load the step counter with `STEP`.
  - If `EN_REQ`=0 or `OTHER_OFF`=0: return to OFF with no segment switched.
- RAMPON:
  - The step counter decrements each cycle.
  - At 0: turn on the next-lowest masked segment that is still off, and reload the counter.
  - Once the last masked segment is on, go to ON.
  - `EN_REQ`=0: go to RAMPOFF. The step counter is loaded with `STEP` and the highest-index on segment turns off on the same edge.
- ON:
  - `EN_REQ`=0: go to RAMPOFF with the same actions as above.
- RAMPOFF:
  - At each step-counter expiry, turn off the highest-index segment that is still on.
  - When the last segment turns off, go to OFF; `SW_OFF` rises on that same edge.
  - `EN_REQ` returning high does not reverse the ramp. Re-arbitration happens from OFF.
- Shoot-through guard: `OTHER_OFF`=0 in RAMPON, ON or RAMPOFF goes to FAULT.
- FAULT (from any state, highest priority):
  - `SEG_ON`=0 immediately on the edge.
  - Exits to OFF only when `FAULT`=0, `EN_REQ`=0 and `OTHER_OFF`=1 are all true.
- Output definitions:
  - `SW_OFF` = (`SEG_ON`==0), registered.
  - `SEG_ON` only ever contains bits set in `mask_q`.

## Timing
- All outputs are registered and take effect on the edge at which the deciding condition is sampled.
- Let the request be sampled at edge E and D = `DEADTIME`.
  - First segment on at E+D+1. D=0 gives E+1.
  - Segment k of M masked segments is on at E+D+1+k·(`STEP`+1).
  - ON is entered with the last segment.
- Let `EN_REQ`=0 be sampled at edge F in ON.
  - The highest segment turns off at F.
  - All segments are off, and `SW_OFF`=1, at F+(M−1)·(`STEP`+1).
- `FAULT` to all segments off: same edge, 0 cycles of added latency.
- A mask with a single bit set skips the ramp: ON is entered at E+D+1.
- Reset asserted mid-ramp clears all segments asynchronously.

## Structure
- Package `pfet_seq_pkg`: state enum and the `NSEG`/`DTW`/`STW` default constants.
- Sub-module `pfet_seg_select`: combinational. Inputs `mask_q` and `SEG_ON`. Returns one-hot next-to-enable (lowest masked bit still off) and next-to-disable (highest bit on), plus an all-on flag.
- Counters and FSM live in the top level.

## Test plan
All scenarios use `NSEG`=4, `DEADTIME`=3, `STEP`=2.
- Mask 1111, `EN_REQ` rises at edge 10 with `OTHER_OFF`=1 → `SEG_ON` steps 0001@14, 0011@17, 0111@20, 1111@23; `SW_OFF` falls @14.
- From ON, `EN_REQ` falls at edge 40 → `SEG_ON` steps 0111@40, 0011@43, 0001@46, 0000@49; `SW_OFF` rises @49; state OFF.
- Mask 0101 → `SEG_ON` 0001@14, then 0101@17, then ON; bits 1 and 3 never set. Changing the mask to 1111 mid-ramp has no effect.
- `OTHER_OFF` drops during DEAD at edge 12 → state OFF, `SEG_ON` stays 0000. Drops during ON → FAULT, `SEG_ON`=0000 and `FAULT_LATCH`=1 on the same edge.
- `FAULT` pulse in RAMPON at 0011 → 0000 on the same edge. Exits FAULT only after both `FAULT` and `EN_REQ` are low.
- `SEG_MASK`=0000 with `EN_REQ`=1 → `ERR_NOMASK`=1, state stays OFF. Separately, `RSTN` asserted at 0111 mid-ramp → all outputs return to their reset values asynchronously.
